// File: rtl/control_unit_seq.sv
// Sequencer for an add/sub/Booth-multiply/non-restoring-divide datapath: Moore FSM driving a 7-bit control word.
// Optional macro CU_SEQ_DIV0_CHK_EN: op 11 with zero_div=1 jumps from LOAD straight to DONE with err raised.
module control_unit_seq #(
    parameter int N = 32,
    localparam int CNT_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bgn,
    input  logic [1:0]       op,
    input  logic [1:0]       booth,
    input  logic             sign,
    input  logic             zero_div,
    output logic [6:0]       c,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             stop,
    output logic             err
);

    typedef enum logic [3:0] {
        IDLE, LOAD, TEST, ADD, SUB, SHIFT, CORR, STORE, DONE
    } state_t;

    state_t     state;
    state_t     nxt;
    logic [1:0] op_q;
    logic       last;

    assign last = (cnt == CNT_W'(N - 1));

    function automatic logic [6:0] dec(input state_t s);
        case (s)
            LOAD:    dec = 7'h01;
            TEST:    dec = 7'h02;
            ADD:     dec = 7'h04;
            SUB:     dec = 7'h0C;
            SHIFT:   dec = 7'h10;
            CORR:    dec = 7'h04;
            STORE:   dec = 7'h20;
            DONE:    dec = 7'h40;
            default: dec = 7'h00;
        endcase
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (bgn) nxt = LOAD;
            LOAD: begin
`ifdef CU_SEQ_DIV0_CHK_EN
                if (op_q == 2'b11 && zero_div) nxt = DONE;
                else
`endif
                case (op_q)
                    2'b00:   nxt = ADD;
                    2'b01:   nxt = SUB;
                    default: nxt = TEST;
                endcase
            end
            TEST: begin
                if (op_q == 2'b10) begin
                    case (booth)
                        2'b01:   nxt = ADD;
                        2'b10:   nxt = SUB;
                        default: nxt = SHIFT;
                    endcase
                end else begin
                    nxt = sign ? ADD : SUB;
                end
            end
            // op[1] separates the iterative ops (return to SHIFT) from single-step add/sub
            ADD, SUB: nxt = op_q[1] ? SHIFT : STORE;
            SHIFT: begin
                if (!last)                        nxt = TEST;
                else if (op_q == 2'b11 && sign)   nxt = CORR;
                else                              nxt = STORE;
            end
            CORR:    nxt = STORE;
            STORE:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

`ifndef CU_SEQ_DIV0_CHK_EN
    logic unused_zero_div;
    assign unused_zero_div = zero_div;
    assign err = 1'b0;
`endif

    // Outputs are registered from the next state so they always equal the decode of the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 2'b00;
            c     <= 7'h00;
            busy  <= 1'b0;
            stop  <= 1'b0;
`ifdef CU_SEQ_DIV0_CHK_EN
            err   <= 1'b0;
`endif
        end else begin
            state <= nxt;
            c     <= dec(nxt);
            busy  <= (nxt != IDLE);
            stop  <= (nxt == DONE);
`ifdef CU_SEQ_DIV0_CHK_EN
            err   <= (state == LOAD) && (nxt == DONE);
`endif
            if (state == IDLE && bgn) op_q <= op;
            if (state == LOAD)
                cnt <= '0;
            else if (state == SHIFT)
                cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit_seq.sv
// Scoreboard bench for control_unit_seq at N=4: driver queues expected responses, monitor checks each stop pulse.
module tb_control_unit_seq;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bgn = 1'b0;
    logic [1:0] op = 2'b00;
    logic [1:0] booth = 2'b00;
    logic       sign = 1'b0;
    logic       zero_div = 1'b0;
    logic [6:0] c;
    logic [1:0] cnt;
    logic       busy;
    logic       stop;
    logic       err;

    control_unit_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .bgn(bgn), .op(op), .booth(booth), .sign(sign),
        .zero_div(zero_div), .c(c), .cnt(cnt), .busy(busy), .stop(stop), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c0; int lat; int err; int nsh; int nc2; int n0c; int ncor; int sig; int trc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act == want) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, want);
    endtask

    function automatic int pk(input int a, input int b, input int d, input int e);
        return (a << 21) | (b << 14) | (d << 7) | e;
    endfunction

    function automatic exp_t mk(input int lat, input int er, input int nsh, input int nc2,
                                input int n0c, input int ncor, input int sig, input int trc);
        exp_t e;
        e.c0 = 0; e.lat = lat; e.err = er; e.nsh = nsh; e.nc2 = nc2;
        e.n0c = n0c; e.ncor = ncor; e.sig = sig; e.trc = trc;
        return e;
    endfunction

    // Monitor: accumulates per-operation observations while busy and checks them at stop.
    initial begin
        int nb, nsh, nc2, n0c, ncor, sig, trc;
        bit after_stop;
        exp_t e;
        nb = 0; nsh = 0; nc2 = 0; n0c = 0; ncor = 0; sig = 0; trc = 0;
        after_stop = 0;
        forever begin
            @(negedge clk);
            if (after_stop) begin
                chk("busy_after_stop", int'(busy), 0);
                chk("stop_single_pulse", int'(stop), 0);
                after_stop = 0;
            end
            if (!busy) begin
                nb = 0; nsh = 0; nc2 = 0; n0c = 0; ncor = 0; sig = 0; trc = 0;
            end else begin
                nb++;
                if (nb <= 4) trc = (trc << 7) | int'(c);
                if (c[4]) begin nsh++; sig = (sig << 2) | int'(cnt); end
                if (c[2]) nc2++;
                if (c == 7'h0C) n0c++;
                if (c == 7'h04 && nsh == N) ncor++;
                if (stop) begin
                    if (q.size() == 0) begin
                        chk("unexpected_stop", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("latency", cyc - e.c0, e.lat);
                        chk("err", int'(err), e.err);
                        chk("shift_count", nsh, e.nsh);
                        chk("c2_count", nc2, e.nc2);
                        chk("sub_count", n0c, e.n0c);
                        chk("corr_count", ncor, e.ncor);
                        chk("cnt_sequence", sig, e.sig);
                        chk("c_trace", trc, e.trc);
                        chk("cnt_at_stop", int'(cnt), 0);
                    end
                    after_stop = 1;
                end
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [1:0] b, input logic s,
                          input logic z, input exp_t e_in);
        exp_t e;
        int i;
        e = e_in;
        op = o; booth = b; sign = s; zero_div = z; bgn = 1'b1;
        e.c0 = cyc;
        q.push_back(e);
        @(negedge clk);
        bgn = 1'b0;
        for (i = 0; i < 100 && busy; i++) @(negedge clk);
        if (busy) chk("op_timeout", 1, 0);
    endtask

    initial begin
        int c0;
        int sig4;
        int i;
        exp_t e0, e1, ediv;
        sig4 = 8'h1B;
        repeat (2) @(negedge clk);
        chk("reset_c", int'(c), 0);
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_stop", int'(stop), 0);
        chk("reset_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b00, 2'b00, 1'b0, 1'b0, mk(4, 0, 0, 1, 0, 0, 0, pk(7'h01, 7'h04, 7'h20, 7'h40)));
        run_op(2'b01, 2'b00, 1'b0, 1'b0, mk(4, 0, 0, 1, 1, 0, 0, pk(7'h01, 7'h0C, 7'h20, 7'h40)));
        run_op(2'b10, 2'b00, 1'b0, 1'b0, mk(11, 0, 4, 0, 0, 0, sig4, pk(7'h01, 7'h02, 7'h10, 7'h02)));
        run_op(2'b10, 2'b10, 1'b0, 1'b0, mk(15, 0, 4, 4, 4, 0, sig4, pk(7'h01, 7'h02, 7'h0C, 7'h10)));
        run_op(2'b10, 2'b01, 1'b0, 1'b0, mk(15, 0, 4, 4, 0, 0, sig4, pk(7'h01, 7'h02, 7'h04, 7'h10)));
        run_op(2'b11, 2'b00, 1'b1, 1'b0, mk(16, 0, 4, 5, 0, 1, sig4, pk(7'h01, 7'h02, 7'h04, 7'h10)));
        run_op(2'b11, 2'b00, 1'b0, 1'b0, mk(15, 0, 4, 4, 4, 0, sig4, pk(7'h01, 7'h02, 7'h0C, 7'h10)));
`ifdef CU_SEQ_DIV0_CHK_EN
        ediv = mk(2, 1, 0, 0, 0, 0, 0, pk(0, 0, 7'h01, 7'h40));
`else
        ediv = mk(15, 0, 4, 4, 4, 0, sig4, pk(7'h01, 7'h02, 7'h0C, 7'h10));
`endif
        run_op(2'b11, 2'b00, 1'b0, 1'b1, ediv);
        zero_div = 1'b0;

        // bgn held through DONE: second op accepted only after one IDLE cycle; mid-op op change ignored.
        e0 = mk(4, 0, 0, 1, 0, 0, 0, pk(7'h01, 7'h04, 7'h20, 7'h40));
        e1 = mk(4, 0, 0, 1, 1, 0, 0, pk(7'h01, 7'h0C, 7'h20, 7'h40));
        op = 2'b00; bgn = 1'b1;
        c0 = cyc;
        e0.c0 = c0; e1.c0 = c0 + 5;
        q.push_back(e0);
        q.push_back(e1);
        @(negedge clk);
        op = 2'b01;
        repeat (5) @(negedge clk);
        bgn = 1'b0;
        for (i = 0; i < 100 && busy; i++) @(negedge clk);
        if (busy) chk("b2b_timeout", 1, 0);
        @(negedge clk);

        // Reset during the third SHIFT of a Booth multiply, with bgn toggling while busy.
        op = 2'b10; booth = 2'b00; bgn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bgn = k[0];
            op = k[1:0];
        end
        @(negedge clk);
        chk("pre_reset_in_shift", int'(c), 7'h10);
        rst = 1'b1; bgn = 1'b0;
        @(negedge clk);
        chk("midrst_c", int'(c), 0);
        chk("midrst_cnt", int'(cnt), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_stop", int'(stop), 0);
        rst = 1'b0;
        run_op(2'b00, 2'b00, 1'b0, 1'b0, mk(4, 0, 0, 1, 0, 0, 0, pk(7'h01, 7'h04, 7'h20, 7'h40)));

        for (i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        chk("pending_expectations", q.size(), 0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_unit_seq.md
CONTROL_UNIT_SEQ -- requirements
Module: control_unit_seq

Interface
REQ-001 SHALL provide parameter N, default 32: operand width and iteration count, legal range 2..64.
REQ-002 SHALL derive CNT_W = ceil(log2(N)) internally as the iteration counter width; it is not user-overridable.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 bgn  input  1  start request; sampled only in IDLE.
REQ-006 op  input  2  operation: 00 add, 01 sub, 10 Booth multiply, 11 non-restoring divide; latched when bgn is accepted.
REQ-007 booth  input  2  multiplier LSB pair {Q0,Q-1}; sampled in TEST for op 10.
REQ-008 sign  input  1  accumulator MSB; sampled in TEST and SHIFT for op 11.
REQ-009 zero_div  input  1  divisor-is-zero flag; sampled in LOAD.
REQ-010 c  output  7  datapath control word; bits c[0]..c[6] are defined in REQ-016.
REQ-011 cnt  output  CNT_W  current iteration index.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 stop  output  1  single-cycle completion pulse.
REQ-014 err  output  1  divide-by-zero flag; valid only while stop is high.

Function
REQ-015 SHALL implement the states IDLE, LOAD, TEST, ADD, SUB, SHIFT, CORR, STORE and DONE; all outputs SHALL be Moore outputs decoded from the state register only.
REQ-016 SHALL drive each c bit in exactly these states and no others:
  - c[0] load operands: LOAD
  - c[1] evaluate test bits: TEST
  - c[2] adder write-back: ADD, SUB, CORR
  - c[3] subtract select: SUB
  - c[4] shift A:Q and increment cnt: SHIFT
  - c[5] output high word: STORE
  - c[6] output low word: DONE
REQ-017 IDLE: bgn=1 -> LOAD and latch op; otherwise stay in IDLE.
REQ-018 LOAD, op 00 -> ADD; op 01 -> SUB; op 10 or 11 -> TEST with cnt cleared to 0.
REQ-019 ADD or SUB reached from LOAD (op 00/01) -> STORE.
REQ-020 TEST, op 10: booth 01 -> ADD; booth 10 -> SUB; booth 00 or 11 -> SHIFT.
REQ-021 TEST, op 11: sign 0 -> SUB; sign 1 -> ADD.
REQ-022 ADD or SUB reached from TEST -> SHIFT.
REQ-023 SHIFT transitions:
  - cnt != N-1: cnt increments and next state is TEST.
  - cnt == N-1: cnt wraps to 0.
  - cnt == N-1 and op 11 with sign 1: next state is CORR.
  - cnt == N-1, any other case: next state is STORE.
REQ-024 CORR -> STORE; STORE -> DONE; DONE -> IDLE; stop=1 only in DONE.
REQ-025 Latency from the bgn-accept edge to stop: op 00/01 = 4 cycles; op 10 = 2N+3 + (number of add/sub iterations) cycles; op 11 = 3N+3 (+1 when CORR is taken) cycles.
REQ-026 bgn, and any op change while busy=1, SHALL be ignored; bgn held high through DONE SHALL start a new operation only from IDLE, i.e. back-to-back operations have one IDLE cycle between them.
REQ-027 cnt SHALL hold its value in all states other than LOAD and SHIFT.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, cnt=0, latched op=00 and all outputs to 0, including mid-operation; the first clock edge after rst deasserts SHALL evaluate bgn normally.

Configuration
REQ-029 Macro CU_SEQ_DIV0_CHK_EN: when defined, LOAD with op 11 and zero_div=1 SHALL go directly to DONE with err=1 during DONE and with none of c[0]..c[5] asserted afterwards.
REQ-030 When CU_SEQ_DIV0_CHK_EN is undefined, zero_div SHALL be ignored, err SHALL be constant 0, and the port list SHALL be unchanged.

Verification
REQ-031 N=4, op 00, bgn pulse: state sequence LOAD,ADD,STORE,DONE; c = 0x01,0x04,0x20,0x40; stop high in the 4th cycle; busy low afterwards.
REQ-032 N=4, op 10, booth held 00: stop 11 cycles after accept; c[4] pulses exactly 4 times; c[2] never asserted; cnt runs 0,1,2,3, then 0.
REQ-033 N=4, op 10, booth held 10: c=0x0C asserted 4 times; stop 15 cycles after accept.
REQ-034 N=4, op 11, sign=1 in the final SHIFT: CORR visited once with c=0x04 between the last SHIFT and STORE; stop at cycle 16.
REQ-035 op 11 with zero_div=1: with CU_SEQ_DIV0_CHK_EN, stop and err high 2 cycles after accept; without it, the normal 3N+3-cycle sequence runs and err=0.
REQ-036 rst asserted during the 3rd SHIFT of op 10, with bgn toggling during busy: next cycle IDLE, c=0 and cnt=0; no spurious stop; a fresh bgn then completes normally.
